// File: rtl/control_fifo_out_pkg.sv
// Shared definitions for the output packer: controller state encoding and default
// parameter values used by the packer, its bus interface and the skid FIFO.
package control_fifo_out_pkg;

   typedef enum logic [2:0] {
      FILL  = 3'd0,
      STALL = 3'd1,
      FLUSH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam int DEF_IN_W         = 256;
   localparam int DEF_RATIO        = 2;
   localparam int DEF_NUM_TASKS    = 32;
   localparam int DEF_SKID_DEPTH   = 4;
   localparam int DEF_EMPTY_CYCLES = 3;

endpackage

// File: rtl/control_fifo_out_pack_if.sv
// Bus between the compute core, the output packer and the wide output FIFO.
// The packer is the slave side; the core/FIFO environment is the master side.
interface control_fifo_out_pack_if
   import control_fifo_out_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int RATIO = DEF_RATIO
);
   logic                    wr_en;
   logic [IN_W-1:0]         wr_data;
   logic                    wr_ready;
   logic                    fifoout_full;
   logic                    fifoout_empty;
   logic                    wr_fifoout_en;
   logic [IN_W*RATIO-1:0]   wr_fifoout_data;

   modport master (
      output wr_en, wr_data, fifoout_full, fifoout_empty,
      input  wr_ready, wr_fifoout_en, wr_fifoout_data
   );

   modport slave (
      input  wr_en, wr_data, fifoout_full, fifoout_empty,
      output wr_ready, wr_fifoout_en, wr_fifoout_data
   );
endinterface

// File: rtl/control_fifo_out_pack_fifo_skid.sv
// Small first-word-fall-through FIFO that parks input words while the packer is
// stalled on a full output FIFO. Push when full and pop when empty are ignored.
module fifo_skid
   import control_fifo_out_pkg::*;
#(
   parameter int W     = DEF_IN_W,
   parameter int DEPTH = DEF_SKID_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr_q];

   always_comb begin
      wptr_d = wptr_q + AW'(do_push);
      rptr_d = rptr_q + AW'(do_pop);
      cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= din;
   end
endmodule

// File: rtl/control_fifo_out_pack.sv
// Packs RATIO narrow result words into one output FIFO word, parks input in a skid
// FIFO under back-pressure, flushes a partial word at end of task and signals done.
// CONTROL_FIFO_OUT_PAD_EN: zero the unfilled lanes of a flushed partial word.
module control_fifo_out_pack
   import control_fifo_out_pkg::*;
#(
   parameter int IN_W         = DEF_IN_W,
   parameter int RATIO        = DEF_RATIO,
   parameter int NUM_TASKS    = DEF_NUM_TASKS,
   parameter int SKID_DEPTH   = DEF_SKID_DEPTH,
   parameter int EMPTY_CYCLES = DEF_EMPTY_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [31:0]          num_data_out,
   input  logic [NUM_TASKS-1:0] task_done,
   control_fifo_out_pack_if.slave bus,
   output logic [31:0]          data_count,
   output logic                 done
);
   localparam int OUT_W = IN_W * RATIO;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int CNT_W = $clog2(EMPTY_CYCLES + 1);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [OUT_W-1:0]     pack_q, pack_d;
   logic [OUT_W-1:0]     out_q, out_d;
   logic                 en_q, en_d;
   logic [31:0]          count_q, count_d;
   logic                 done_q, done_d;
   logic [CNT_W-1:0]     drain_q, drain_d;

   logic                 skid_push, skid_pop, skid_full, skid_empty;
   logic [IN_W-1:0]      skid_dout, src_word;
   logic [OUT_W-1:0]     flush_word;
   logic                 end_raw, wr_ready, accept;

   fifo_skid #(.W(IN_W), .DEPTH(SKID_DEPTH)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (skid_push),
      .pop   (skid_pop),
      .din   (bus.wr_data),
      .dout  (skid_dout),
      .full  (skid_full),
      .empty (skid_empty)
   );

   // Input is refused once the end condition holds so no word beyond the task is taken.
   assign end_raw  = (&task_done) || (count_q >= num_data_out);
   assign wr_ready = !rst && start && (state_q == FILL || state_q == STALL)
                     && !skid_full && !end_raw;
   assign accept   = bus.wr_en && wr_ready;
   assign src_word = skid_empty ? bus.wr_data : skid_dout;

   for (genvar gi = 0; gi < RATIO; gi++) begin : g_flush
`ifdef CONTROL_FIFO_OUT_PAD_EN
      assign flush_word[gi*IN_W +: IN_W] =
         (gi < int'(idx_q)) ? pack_q[gi*IN_W +: IN_W] : '0;
`else
      assign flush_word[gi*IN_W +: IN_W] = pack_q[gi*IN_W +: IN_W];
`endif
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pack_d    = pack_q;
      out_d     = out_q;
      en_d      = 1'b0;
      count_d   = count_q;
      done_d    = done_q;
      drain_d   = drain_q;
      skid_push = 1'b0;
      skid_pop  = 1'b0;
      if (start) begin
         if (accept) count_d = count_q + 32'd1;
         unique case (state_q)
            FILL: begin
               if (skid_empty && end_raw) begin
                  state_d = FLUSH;
               end else if (!skid_empty || accept) begin
                  // Skid head is older than the live input, so it goes first.
                  skid_pop  = !skid_empty;
                  skid_push = accept && !skid_empty;
                  for (int k = 0; k < RATIO; k++) begin
                     if (idx_q == IDX_W'(k)) pack_d[k*IN_W +: IN_W] = src_word;
                  end
                  if (idx_q == IDX_W'(RATIO-1)) begin
                     if (!bus.fifoout_full) begin
                        out_d = pack_d;
                        en_d  = 1'b1;
                        idx_d = '0;
                     end else begin
                        state_d = STALL;
                     end
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            STALL: begin
               skid_push = accept;
               if (!bus.fifoout_full) begin
                  out_d   = pack_q;
                  en_d    = 1'b1;
                  idx_d   = '0;
                  state_d = FILL;
               end
            end
            FLUSH: begin
               if (idx_q == '0) begin
                  state_d = DRAIN;
               end else if (!bus.fifoout_full) begin
                  out_d   = flush_word;
                  en_d    = 1'b1;
                  idx_d   = '0;
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (drain_q == CNT_W'(EMPTY_CYCLES)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  drain_d = bus.fifoout_empty ? drain_q + 1'b1 : '0;
               end
            end
            DONE:    done_d  = 1'b1;
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         pack_q  <= '0;
         out_q   <= '0;
         en_q    <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pack_q  <= pack_d;
         out_q   <= out_d;
         en_q    <= en_d;
         count_q <= count_d;
         done_q  <= done_d;
         drain_q <= drain_d;
      end
   end

   assign bus.wr_ready        = wr_ready;
   assign bus.wr_fifoout_en   = en_q;
   assign bus.wr_fifoout_data = out_q;
   assign data_count          = count_q;
   assign done                = done_q;
endmodule

// File: tb/tb_control_fifo_out_pack.sv
// Directed bench for the output packer: expected FIFO words are queued as stimulus
// is issued and a negedge monitor checks every write strobe against the queue.
module tb_control_fifo_out_pack;
   localparam int IN_W = 8;
   localparam int RATIO = 4;
   localparam int NT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b1;
   logic [31:0]   num_data_out = 32'd8;
   logic [NT-1:0] task_done = '0;
   logic [31:0]   data_count;
   logic          done;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   control_fifo_out_pack_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

   control_fifo_out_pack #(
      .IN_W(IN_W), .RATIO(RATIO), .NUM_TASKS(NT), .SKID_DEPTH(4), .EMPTY_CYCLES(3)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_data_out(num_data_out),
      .task_done(task_done), .bus(bus), .data_count(data_count), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end else begin
         $display("check %s got=%0h ok", name, got);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected word.
   always @(negedge clk) begin
      if (bus.wr_fifoout_en) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got=%h required=none", bus.wr_fifoout_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.wr_fifoout_data !== e) begin
               bad++;
               $display("FAIL fifo_write got=%h required=%h", bus.wr_fifoout_data, e);
            end else begin
               $display("write %h ok", bus.wr_fifoout_data);
            end
         end
      end
   end

   task automatic do_reset(input logic [31:0] num, input logic [NT-1:0] td);
      @(negedge clk);
      rst = 1'b1;
      bus.wr_en = 1'b0;
      bus.fifoout_full = 1'b0;
      bus.fifoout_empty = 1'b1;
      num_data_out = num;
      task_done = td;
      @(negedge clk);
      @(negedge clk);
      check("rst_wr_fifoout_en", 64'(bus.wr_fifoout_en), 64'd0);
      check("rst_wr_fifoout_data", 64'(bus.wr_fifoout_data), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_data_count", 64'(data_count), 64'd0);
      check("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_data = d;
      for (int c = 0; c < 100 && !ok; c++) begin
         if (c > 0) @(negedge clk);
         ok = bus.wr_ready;
         @(posedge clk);
      end
      if (!ok) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int c = 0; c < 60 && !done; c++) @(negedge clk);
      check(name, 64'(done), 64'd1);
      check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Empty pattern bit k-1 is sampled at rising edge k after reset release.
   task automatic drain_run(input string name, input logic [11:0] pat, input int done_k);
      for (int k = 1; k <= 10; k++) begin
         bus.fifoout_empty = pat[k-1];
         @(negedge clk);
         check($sformatf("%s_k%0d", name, k), 64'(done), 64'(k >= done_k));
      end
      bus.fifoout_empty = 1'b1;
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      bus.fifoout_full = 1'b0;
      bus.fifoout_empty = 1'b1;

      // Basic packing with a start=0 freeze in the middle
      do_reset(32'd8, '0);
      exp_q.push_back(32'h04030201);
      exp_q.push_back(32'h08070605);
      send(8'h01);
      send(8'h02);
      @(negedge clk);
      bus.wr_en = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("freeze_wr_ready", 64'(bus.wr_ready), 64'd0);
      check("freeze_count", 64'(data_count), 64'd2);
      start = 1'b1;
      for (int i = 3; i <= 8; i++) send(8'(i));
      idle();
      wait_done("basic_done");
      check("basic_count", 64'(data_count), 64'd8);

      // Back-pressure: word 1 held, words 5..8 parked in the skid, word 9 refused
      do_reset(32'd12, '0);
      exp_q.push_back(32'h04030201);
      exp_q.push_back(32'h08070605);
      exp_q.push_back(32'h0C0B0A09);
      for (int i = 1; i <= 3; i++) send(8'(i));
      bus.fifoout_full = 1'b1;
      for (int i = 4; i <= 8; i++) send(8'(i));
      @(negedge clk);
      bus.wr_data = 8'h09;
      check("skid_full_wr_ready", 64'(bus.wr_ready), 64'd0);
      check("skid_full_count", 64'(data_count), 64'd8);
      bus.fifoout_full = 1'b0;
      for (int i = 9; i <= 12; i++) send(8'(i));
      idle();
      wait_done("stall_done");
      check("stall_count", 64'(data_count), 64'd12);

      // Partial flush of two lanes
      do_reset(32'd6, '0);
      exp_q.push_back(32'h04030201);
`ifdef CONTROL_FIFO_OUT_PAD_EN
      exp_q.push_back(32'h00000605);
`else
      exp_q.push_back(32'h04030605);
`endif
      for (int i = 1; i <= 6; i++) send(8'(i));
      idle();
      wait_done("flush_done");

      // All tasks done with no input: no write, done after FLUSH, DRAIN and 3 empties
      do_reset(32'd8, '1);
      drain_run("notask_done", 12'hFFF, 6);

      // fifoout_empty drops at edge 5, restarting the drain count
      do_reset(32'd8, '1);
      drain_run("toggle_done", 12'b1111_1110_1111, 9);

      // Reset with two lanes filled, then a clean second run
      do_reset(32'd8, '0);
      send(8'h01);
      send(8'h02);
      idle();
      do_reset(32'd8, '0);
      exp_q.push_back(32'h14131211);
      exp_q.push_back(32'h18171615);
      for (int i = 8'h11; i <= 8'h18; i++) send(8'(i));
      idle();
      wait_done("rerun_done");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
